// File: rtl/morse_pkg.sv
// Shared encodings and entry layout for the Morse character assembler.
// Entry layout, LSB first: code, len, ovf, space.
package morse_pkg;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_DOT,
        EV_DASH,
        EV_CHAR,
        EV_WORD
    } event_e;

    function automatic int len_w(input int max_symbols);
        return $clog2(max_symbols + 1);
    endfunction

    function automatic int code_lsb(input int max_symbols);
        return 0 * max_symbols;
    endfunction

    function automatic int len_lsb(input int max_symbols);
        return max_symbols;
    endfunction

    function automatic int ovf_bit(input int max_symbols);
        return max_symbols + len_w(max_symbols);
    endfunction

    function automatic int space_bit(input int max_symbols);
        return max_symbols + len_w(max_symbols) + 1;
    endfunction

    function automatic int entry_w(input int max_symbols);
        return max_symbols + len_w(max_symbols) + 2;
    endfunction

endpackage

// File: rtl/morse_char_assembler_if.sv
// Completed-character stream: valid/ready handshake plus entry fields.
interface morse_char_assembler_if #(
    parameter int MAX_SYMBOLS = 5,
    parameter int LEN_W       = $clog2(MAX_SYMBOLS + 1)
) ();

    logic                   out_valid;
    logic                   out_ready;
    logic [MAX_SYMBOLS-1:0] out_code;
    logic [LEN_W-1:0]       out_len;
    logic                   space;
    logic                   out_ovf;

    modport master (
        output out_valid,
        output out_code,
        output out_len,
        output space,
        output out_ovf,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_code,
        input  out_len,
        input  space,
        input  out_ovf,
        output out_ready
    );

endinterface

// File: rtl/morse_char_fifo.sv
// First-word-fall-through FIFO for completed characters.
// A push on a full FIFO succeeds only when a pop happens in the same cycle.
module morse_char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             wr_en;
    logic             rd_en;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign rdata = mem[rptr];

    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            cnt <= cnt + CW'(wr_en) - CW'(rd_en);
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/morse_char_assembler.sv
// Collects dot/dash events into characters, closes them on gaps and
// queues completed entries for a valid/ready consumer.
module morse_char_assembler
    import morse_pkg::*;
#(
    parameter int MAX_SYMBOLS = 5,
    parameter int FIFO_DEPTH  = 4,
    parameter int LEN_W       = $clog2(MAX_SYMBOLS + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic writing,
    input  logic dot,
    input  logic dash,
    input  logic interchar,
    input  logic interword,
    output logic read_out,
    output logic err,
    output logic dropped,
    morse_char_assembler_if.master stream
);

    localparam int ENTRY_W   = entry_w(MAX_SYMBOLS);
    localparam int SPACE_BIT = space_bit(MAX_SYMBOLS);
    localparam int CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_SYMBOLS);

    event_e                 ev;
    logic                   collision;
    logic [MAX_SYMBOLS-1:0] code_reg;
    logic [MAX_SYMBOLS-1:0] code_nxt;
    logic [LEN_W-1:0]       len_reg;
    logic [LEN_W-1:0]       len_nxt;
    logic                   ovf_reg;
    logic                   ovf_nxt;
    logic                   last_space;
    logic                   last_space_nxt;
    logic                   push;
    logic                   sym_ovf;
    logic [ENTRY_W-1:0]     push_entry;
    logic [ENTRY_W-1:0]     head;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [CW-1:0]          fifo_count;

    always_comb begin
        ev = EV_NONE;
        if (writing) begin
            priority case (1'b1)
                interword: ev = EV_WORD;
                interchar: ev = EV_CHAR;
                dash:      ev = EV_DASH;
                dot:       ev = EV_DOT;
                default:   ev = EV_NONE;
            endcase
        end
    end

    assign collision = writing &&
        ($countones({dot, dash, interchar, interword}) > 1);

    // Next accumulator state
    always_comb begin
        code_nxt       = code_reg;
        len_nxt        = len_reg;
        ovf_nxt        = ovf_reg;
        last_space_nxt = last_space;
        case (ev)
            EV_DOT, EV_DASH: begin
                if (len_reg < MAX_LEN) begin
                    code_nxt = code_reg |
                        (MAX_SYMBOLS'(ev == EV_DASH ? DASH : DOT) << len_reg);
                    len_nxt        = len_reg + 1'b1;
                    last_space_nxt = 1'b0;
                end else begin
                    ovf_nxt = 1'b1;
                end
            end
            EV_CHAR: begin
                if (len_reg != '0) begin
                    code_nxt       = '0;
                    len_nxt        = '0;
                    ovf_nxt        = 1'b0;
                    last_space_nxt = 1'b0;
                end
            end
            EV_WORD: begin
                code_nxt       = '0;
                len_nxt        = '0;
                ovf_nxt        = 1'b0;
                last_space_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        push       = 1'b0;
        sym_ovf    = 1'b0;
        push_entry = {1'b0, ovf_reg, len_reg, code_reg};
        case (ev)
            EV_DOT, EV_DASH: sym_ovf = (len_reg == MAX_LEN);
            EV_CHAR:         push = (len_reg != '0);
            EV_WORD: begin
                push = (len_reg != '0) || !last_space;
                push_entry[SPACE_BIT] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_reg   <= '0;
            len_reg    <= '0;
            ovf_reg    <= 1'b0;
            last_space <= 1'b0;
            read_out   <= 1'b0;
            err        <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            code_reg   <= code_nxt;
            len_reg    <= len_nxt;
            ovf_reg    <= ovf_nxt;
            last_space <= last_space_nxt;
            read_out   <= (ev != EV_NONE);
            err        <= collision || sym_ovf;
            dropped    <= push && full && !pop;
        end
    end

    assign pop = (fifo_count != '0) && stream.out_ready;

    morse_char_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign stream.out_valid = !empty;
    assign {stream.space, stream.out_ovf, stream.out_len, stream.out_code} =
        empty ? '0 : head;

endmodule

// File: doc/morse_char_assembler.md
# morse_char_assembler

Parametrised Morse character assembler between the dot/dash/gap classifier and the character decoder/display path. Accumulates up to MAX_SYMBOLS dot/dash events into a symbol code, closes the character on an inter-character or inter-word gap and buffers completed characters in a FIFO. The FIFO drains through a valid/ready handshake. Unlike the fixed 3-symbol receiver, it supports any character length and decoupled consumers, and it reports overflow and drops explicitly.

## Interface
- MAX_SYMBOLS, 5: maximum symbols per character; 5 covers letters and digits.
- FIFO_DEPTH, 4: completed-character buffer depth; power of two, at least 2.
- LEN_W, $clog2(MAX_SYMBOLS+1): derived length-field width; not overridden.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- writing  in  1  input enable; events are ignored while low.
- dot, dash, interchar, interword  in  1 each  one-cycle event pulses from the classifier.
- read_out  out  1  one-cycle pulse: an event was consumed this cycle.
- err  out  1  one-cycle pulse: symbol overflow or event collision.
- dropped  out  1  one-cycle pulse: a completed entry was lost because the FIFO was full.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_code  out  MAX_SYMBOLS  bit i is symbol i (0 = dot, 1 = dash); the first symbol is in bit 0; unused bits are 0.
- out_len  out  LEN_W  symbol count, 0 to MAX_SYMBOLS.
- space  out  1  a word gap follows this entry. An entry with out_len = 0 is a space-only entry.
- out_ovf  out  1  the character exceeded MAX_SYMBOLS symbols and was truncated.

## Operation
- Accumulator state: code_reg, len_reg, ovf_reg, last_space.
- Event priority within one cycle: interword > interchar > dash > dot. Only the winning event acts. If more than one event is high, err pulses.
- dot/dash with len_reg < MAX_SYMBOLS: code_reg[len_reg] <= dash; len_reg increments; last_space <= 0; read_out pulses.
- dot/dash with len_reg = MAX_SYMBOLS: the symbol is discarded; ovf_reg <= 1; err and read_out pulse.
- interchar with len_reg > 0: push {space=0, ovf_reg, len_reg, code_reg}, then clear the accumulator; last_space <= 0.
- interchar with len_reg = 0: no push.
- interword with len_reg > 0: push the entry with space=1; last_space <= 1.
- interword with len_reg = 0 and last_space = 0: push a space-only entry; last_space <= 1.
- interword with len_reg = 0 and last_space = 1: no push, so repeated gaps collapse.
- read_out pulses for every consumed gap event, including those that cause no push.
- Push when the FIFO is full and no pop occurs in the same cycle: the entry is lost and dropped pulses. The accumulator still clears.
- Push and pop in the same cycle on a full FIFO: both succeed and the count is unchanged.
- writing = 0: all events ignored; no read_out, err or state change. FIFO drain continues.

## Timing
- read_out, err and dropped are registered: they are high in the cycle after the event edge, for exactly one cycle.
- Gap event to out_valid on an empty FIFO: 1 cycle. The FIFO is first-word-fall-through.
- Pop occurs when out_valid && out_ready. The next head, or out_valid = 0, appears on the following cycle.
- Output fields hold stable while out_valid && !out_ready.
- Reset value of every output: out_valid, out_code, out_len, space, out_ovf, read_out, err and dropped are all 0. The accumulator, last_space and the FIFO pointers/count are also 0.
- Reset asserted mid-character or mid-drain clears everything immediately and asynchronously. No partial entry is emitted after release.

## Structure
- Package morse_pkg holds the DOT/DASH bit encodings, the entry field offsets/widths and the ENTRY_W = MAX_SYMBOLS + LEN_W + 2 calculation.
- Sub-module morse_char_fifo, parametrised by width and depth, provides full/empty/count and same-cycle push+pop. The assembler FSM/accumulator lives in the top module.

## Test plan
- MAX_SYMBOLS = 5, FIFO_DEPTH = 4, out_ready = 1. Stimulus: dot, dash, interchar. Response: one entry code = 00010, len = 2, space = 0, ovf = 0; out_valid one cycle after interchar.
- Stimulus: dash ×3, interword, interword. Response: exactly one entry code = 00111, len = 3, space = 1; the second interword pulses read_out only.
- Stimulus: dot ×6, interchar. Response: err on the 6th dot; entry code = 00000, len = 5, ovf = 1.
- out_ready = 0. Stimulus: 5 single-dash characters. Response: 4 stored; dropped pulses on the 5th; raising out_ready drains 4 entries of code = 00001, len = 1, in order.
- Stimulus: accumulated len = 1 (dot), then dot and interchar in the same cycle. Response: interchar wins; entry len = 1; err pulses.
- Stimulus: accumulated len = 3 and FIFO holding 2 entries, then reset low. Response: all outputs 0 immediately; after release, dash + interchar yields code = 00001, len = 1 as the only entry.
